// File: rtl/regfile_mult_seq_if.sv
// regfile_mult_seq_if: command, pipeline, memory and register-file signals of the transfer sequencer
interface regfile_mult_seq_if;
  logic start;
  logic is_load;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic busy;
  logic done;
  logic stall;
  logic pl_write;
  logic [3:0] pl_wrAddr;
  logic [31:0] pl_wrData;
  logic mem_req;
  logic mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic mem_ack;
  logic [31:0] mem_rdata;
  logic rf_rmEn;
  logic [3:0] rf_rdAddrm;
  logic [31:0] rf_rdDatam;
  logic rf_write;
  logic [3:0] rf_wrAddr;
  logic [31:0] rf_wrData;
  modport slave (
    input start, is_load, reg_list, base_addr, pl_write, pl_wrAddr, pl_wrData,
          mem_ack, mem_rdata, rf_rdDatam,
    output busy, done, stall, mem_req, mem_we, mem_addr, mem_wdata,
           rf_rmEn, rf_rdAddrm, rf_write, rf_wrAddr, rf_wrData
  );
  modport master (
    output start, is_load, reg_list, base_addr, pl_write, pl_wrAddr, pl_wrData,
           mem_ack, mem_rdata, rf_rdDatam,
    input busy, done, stall, mem_req, mem_we, mem_addr, mem_wdata,
          rf_rmEn, rf_rdAddrm, rf_write, rf_wrAddr, rf_wrData
  );
endinterface

// File: rtl/regfile_mult_seq.sv
// regfile_mult_seq: walks a register list, moving one register per memory access (load/store multiple)
module regfile_mult_seq (
  input logic clk,
  input logic rst,
  regfile_mult_seq_if.slave b
);
  typedef enum logic [2:0] {IDLE, RD, MEM_W, MEM_R, WB, DONE} state_t;
  state_t state, nxt;
  logic [15:0] mask, rest;
  logic [31:0] cnt, wdata, rdata;
  logic [3:0] cur;
  logic idle, wb, step;
  always_comb begin
    cur = '0;
    for (int i = 15; i >= 0; i--) if (mask[i]) cur = i[3:0];
  end
  assign rest = mask & ~(16'd1 << cur);
  assign idle = state == IDLE;
  assign wb = state == WB;
  assign step = (state == MEM_W && b.mem_ack) || wb;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (b.start) nxt = b.reg_list == '0 ? DONE : b.is_load ? MEM_R : RD;
      RD: nxt = MEM_W;
      MEM_W: if (b.mem_ack) nxt = rest != '0 ? RD : DONE;
      MEM_R: if (b.mem_ack) nxt = WB;
      WB: nxt = rest != '0 ? MEM_R : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mask <= '0;
      cnt <= '0;
      wdata <= '0;
      rdata <= '0;
    end else begin
      state <= nxt;
      if (idle && b.start) begin
        mask <= b.reg_list;
        cnt <= b.base_addr;
      end
      if (state == RD) wdata <= b.rf_rdDatam;
      if (state == MEM_R && b.mem_ack) rdata <= b.mem_rdata;
      if (step) begin
        mask <= rest;
        cnt <= cnt + 32'd4;
      end
    end
  end
  assign b.busy = !idle;
  assign b.stall = !idle;
  assign b.done = state == DONE;
  assign b.mem_req = state == MEM_W || state == MEM_R;
  assign b.mem_we = state == MEM_W;
  assign b.mem_addr = b.mem_req ? cnt : '0;
  assign b.mem_wdata = b.mem_we ? wdata : '0;
  assign b.rf_rmEn = state == RD;
  assign b.rf_rdAddrm = state == RD ? cur : '0;
  // the pipeline owns the write port only while idle
  assign b.rf_write = idle ? b.pl_write : wb;
  assign b.rf_wrAddr = idle ? b.pl_wrAddr : wb ? cur : '0;
  assign b.rf_wrData = idle ? b.pl_wrData : wb ? rdata : '0;
endmodule

// File: tb/tb_regfile_mult_seq.sv
// tb_regfile_mult_seq: scoreboard bench with register-file and memory models around the sequencer
module tb_regfile_mult_seq;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] data;} mreq_t;
  typedef struct {logic [3:0] a; logic [31:0] d;} rw_t;
  logic clk = 0, rst = 1;
  regfile_mult_seq_if b();
  regfile_mult_seq dut (.clk(clk), .rst(rst), .b(b));
  always #5 clk = ~clk;
  int errors = 0, total = 0, ack_dly = 0;
  mreq_t mem_q[$];
  rw_t rf_q[$];
  logic [31:0] ref_rf[16], phys_rf[16];
  logic [31:0] ref_mem[logic [31:0]], phys_mem[logic [31:0]];
  function automatic logic [31:0] init_val(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction
  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] phys_rd(logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // monitor + register-file model: everything sampled on the falling edge
  initial begin
    logic prev_req = 0, prev_ack = 0;
    logic [31:0] prev_addr = 0;
    mreq_t m;
    rw_t w;
    forever begin
      @(negedge clk);
      if (prev_req === 1'b1 && prev_ack === 1'b0 && b.mem_req === 1'b1 && !rst)
        chk("mem_addr_hold", b.mem_addr, prev_addr);
      if (b.mem_req === 1'b1 && b.mem_ack === 1'b1) begin
        if (mem_q.size() == 0) begin
          total++; errors++;
          $display("FAIL mem_unexpected: got addr %0h we %0b expected no access", b.mem_addr, b.mem_we);
        end else begin
          m = mem_q.pop_front();
          chk("mem_addr", b.mem_addr, m.addr);
          chk("mem_we", {31'd0, b.mem_we}, {31'd0, m.we});
          if (m.we) chk("mem_wdata", b.mem_wdata, m.data);
        end
        if (b.mem_we === 1'b1) phys_mem[b.mem_addr] = b.mem_wdata;
      end
      if (b.rf_write === 1'b1) begin
        if (rf_q.size() == 0) begin
          total++; errors++;
          $display("FAIL rf_unexpected: got write r%0d=%0h expected none", b.rf_wrAddr, b.rf_wrData);
        end else begin
          w = rf_q.pop_front();
          chk("rf_wrAddr", {28'd0, b.rf_wrAddr}, {28'd0, w.a});
          chk("rf_wrData", b.rf_wrData, w.d);
        end
        phys_rf[b.rf_wrAddr] = b.rf_wrData;
      end
      b.rf_rdDatam = phys_rf[b.rf_rdAddrm];
      prev_req = b.mem_req; prev_ack = b.mem_ack; prev_addr = b.mem_addr;
    end
  end
  // memory responder: acks after ack_dly wait cycles
  initial begin
    int wcnt = 0;
    b.mem_ack = 0; b.mem_rdata = 0;
    forever begin
      @(posedge clk); #1;
      if (b.mem_req === 1'b1 && wcnt == ack_dly) begin
        b.mem_ack = 1; b.mem_rdata = phys_rd(b.mem_addr); wcnt = 0;
      end else if (b.mem_req === 1'b1) begin
        b.mem_ack = 0; wcnt++;
      end else begin
        b.mem_ack = 0; wcnt = 0;
      end
    end
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  task automatic pl_wr(input logic [3:0] a, input logic [31:0] d);
    b.pl_write = 1; b.pl_wrAddr = a; b.pl_wrData = d;
    rf_q.push_back('{a: a, d: d});
    ref_rf[a] = d;
    @(posedge clk); #1;
    b.pl_write = 0;
  endtask
  task automatic cmd(input logic ld, input logic [15:0] lst, input logic [31:0] base, input int dly,
                     input bit noise, input bit plw, input logic [3:0] pa, input logic [31:0] pd);
    int n = 0, bcyc = 0, dcyc = 0, dcnt = 0, wcyc = 0, rcyc = 0, exp_busy;
    logic [31:0] a = base;
    ack_dly = dly;
    if (plw) begin
      rf_q.push_back('{a: pa, d: pd});
      ref_rf[pa] = pd;
    end
    for (int i = 0; i < 16; i++) if (lst[i]) begin
      n++;
      if (ld) begin
        mem_q.push_back('{addr: a, we: 1'b0, data: 32'd0});
        rf_q.push_back('{a: i[3:0], d: ref_rd(a)});
        ref_rf[i] = ref_rd(a);
      end else begin
        mem_q.push_back('{addr: a, we: 1'b1, data: ref_rf[i]});
        ref_mem[a] = ref_rf[i];
      end
      a += 32'd4;
    end
    exp_busy = n == 0 ? 1 : 2 * n + 1 + n * dly;
    b.start = 1; b.is_load = ld; b.reg_list = lst; b.base_addr = base;
    b.pl_write = plw; b.pl_wrAddr = pa; b.pl_wrData = pd;
    @(posedge clk); #1;
    b.start = 0; b.pl_write = 0;
    if (noise) begin
      b.start = 1; b.is_load = 1'($urandom); b.reg_list = 16'($urandom); b.base_addr = $urandom;
      b.pl_write = 1; b.pl_wrAddr = 4'($urandom); b.pl_wrData = $urandom;
    end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (b.busy !== 1'b1) break;
      bcyc++;
      if (b.rf_write === 1'b1) wcyc++;
      if (b.mem_req === 1'b1) rcyc++;
      if (b.done === 1'b1) begin
        dcnt++; dcyc = bcyc;
        b.start = 0; b.pl_write = 0;
      end
    end
    chk("busy_len", bcyc, exp_busy);
    chk("done_cnt", dcnt, 1);
    chk("done_pos", dcyc, exp_busy);
    chk("rf_write_cycles", wcyc, ld ? n : 0);
    chk("mem_req_cycles", rcyc, n * (dly + 1));
    chk("mem_q_left", mem_q.size(), 0);
    chk("rf_q_left", rf_q.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic chk_reset_outs(string tag);
    chk({tag, "_busy"}, {31'd0, b.busy}, 0);
    chk({tag, "_done"}, {31'd0, b.done}, 0);
    chk({tag, "_stall"}, {31'd0, b.stall}, 0);
    chk({tag, "_mem_req"}, {31'd0, b.mem_req}, 0);
    chk({tag, "_mem_we"}, {31'd0, b.mem_we}, 0);
    chk({tag, "_rf_rmEn"}, {31'd0, b.rf_rmEn}, 0);
    chk({tag, "_rf_write"}, {31'd0, b.rf_write}, 0);
    chk({tag, "_mem_addr"}, b.mem_addr, 0);
    chk({tag, "_mem_wdata"}, b.mem_wdata, 0);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_rf[i] = 32'd0; phys_rf[i] = 32'd0;
    end
    b.start = 0; b.is_load = 0; b.reg_list = 0; b.base_addr = 0;
    b.pl_write = 0; b.pl_wrAddr = 0; b.pl_wrData = 0; b.rf_rdDatam = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_reset_outs("reset");
    pl_wr(4'd0, 32'd0);
    pl_wr(4'd2, 32'd2);
    cmd(1'b0, 16'h0005, 32'h100, 0, 0, 0, 4'd0, 32'd0);
    chk("store_mem_104", phys_rd(32'h104), 32'd2);
    ref_mem[32'h200] = 32'hAAAA0000; phys_mem[32'h200] = 32'hAAAA0000;
    ref_mem[32'h204] = 32'h5555FFFF; phys_mem[32'h204] = 32'h5555FFFF;
    cmd(1'b1, 16'h8001, 32'h200, 0, 0, 0, 4'd0, 32'd0);
    chk("load_r0", phys_rf[0], 32'hAAAA0000);
    chk("load_r15", phys_rf[15], 32'h5555FFFF);
    cmd(1'b1, 16'h0010, 32'h400, 3, 0, 0, 4'd0, 32'd0);
    cmd(1'b0, 16'h0000, 32'h500, 0, 0, 0, 4'd0, 32'd0);
    cmd(1'b0, 16'h0000, 32'h500, 0, 1, 1, 4'd7, 32'h77);
    cmd(1'b0, 16'h00F0, 32'h600, 1, 1, 1, 4'd5, 32'h1234_5678);
    cmd(1'b1, 16'h0106, 32'h700, 2, 1, 0, 4'd0, 32'd0);
    pl_wr(4'd9, 32'hDEAD_BEEF);
    cmd(1'b1, 16'h0003, 32'hFFFFFFFC, 0, 0, 0, 4'd0, 32'd0);
    // reset while the second load waits for memory: r0 lands, r1 must not
    ack_dly = 0;
    mem_q.push_back('{addr: 32'h300, we: 1'b0, data: 32'd0});
    rf_q.push_back('{a: 4'd0, d: ref_rd(32'h300)});
    ref_rf[0] = ref_rd(32'h300);
    b.start = 1; b.is_load = 1; b.reg_list = 16'h0003; b.base_addr = 32'h300;
    @(posedge clk); #1;
    b.start = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b.rf_write === 1'b1) break;
    end
    ack_dly = 20;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk_reset_outs("midreset");
    repeat (4) @(posedge clk);
    #1;
    chk("midreset_r1", phys_rf[1], ref_rf[1]);
    chk("midreset_mem_q", mem_q.size(), 0);
    chk("midreset_rf_q", rf_q.size(), 0);
    for (int k = 0; k < 24; k++) begin
      logic [15:0] lst;
      lst = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 2) == 0) pl_wr(4'($urandom), $urandom);
      cmd(1'($urandom), lst, $urandom & 32'hFFFFFFFC, $urandom_range(0, 3),
          1'($urandom), 1'($urandom), 4'($urandom), $urandom);
    end
    for (int i = 0; i < 16; i++) chk("final_rf", phys_rf[i], ref_rf[i]);
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end
endmodule
